// File: rtl/prefix_sum_stage.sv
// Final stage of the parallel-prefix adder: turns group generate/propagate terms into
// sum/carry/overflow, chains the carry across beats, and buffers results in a 2-entry FIFO.
module prefix_sum_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             cin,
    input  logic [WIDTH-1:0] prop_bit,
    input  logic [WIDTH-1:0] grp_gen,
    input  logic [WIDTH-1:0] grp_prop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_last
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             last;
    } beat_t;

    beat_t       mem_q [2];
    beat_t       mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        carry_q, carry_d;

    logic             ci;
    logic [WIDTH-1:0] carry_vec;
    beat_t            res;
    logic             push;
    logic             pop;
    beat_t            head;

    // Group terms assume zero carry-in, so the real carry-in is folded in once per bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        carry_vec    = '0;
        ci           = in_first ? cin : carry_q;
        carry_vec[0] = ci;
        for (int i = 1; i < WIDTH; i++) begin
            carry_vec[i] = grp_gen[i-1] | (grp_prop[i-1] & ci);
        end
        res.sum  = prop_bit ^ carry_vec;
        res.cout = grp_gen[WIDTH-1] | (grp_prop[WIDTH-1] & ci);
        res.ovf  = carry_vec[WIDTH-1] ^ res.cout;
        res.last = in_last;
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        carry_d  = carry_q;
        if (push) begin
            mem_d[wr_ptr_q] = res;
            wr_ptr_d        = ~wr_ptr_q;
            carry_d         = in_last ? 1'b0 : res.cout;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is reset too, because the head entry drives the outputs
            // directly and they must read zero straight out of reset.
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            carry_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign sum      = head.sum;
    assign cout     = head.cout;
    assign ovf      = head.ovf;
    assign out_last = head.last;

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Directed and randomized bench for prefix_sum_stage (WIDTH=8); the random phase checks
// every beat against an independent wide-integer addition model.
module tb_prefix_sum_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_first;
    logic       in_last;
    logic       cin;
    logic [7:0] prop_bit;
    logic [7:0] grp_gen;
    logic [7:0] grp_prop;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       out_last;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    bit   prod_done;

    always #5 clk = ~clk;

    prefix_sum_stage #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_first (in_first),
        .in_last  (in_last),
        .cin      (cin),
        .prop_bit (prop_bit),
        .grp_gen  (grp_gen),
        .grp_prop (grp_prop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .out_last (out_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Stand-in for the upstream prefix tree: group terms with zero carry-in.
    function automatic void tree(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] g, output logic [7:0] p);
        logic [7:0] pb;
        logic [7:0] gb;
        pb   = a ^ b;
        gb   = a & b;
        g[0] = gb[0];
        p[0] = pb[0];
        for (int i = 1; i < 8; i++) begin
            g[i] = gb[i] | (pb[i] & g[i-1]);
            p[i] = pb[i] & p[i-1];
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push_beat(input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic f, input logic l);
        logic [7:0] g;
        logic [7:0] p;
        int n;
        tree(a, b, g, p);
        prop_bit = a ^ b;
        grp_gen  = g;
        grp_prop = p;
        cin      = c;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("accept_timeout", 32'(n), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [7:0] s, input logic c,
                              input logic o, input logic l);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(sum),       32'(s));
        check({tag, "_cout"},  32'(cout),      32'(c));
        check({tag, "_ovf"},   32'(ovf),       32'(o));
        check({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        cin       = 1'b0;
        prop_bit  = '0;
        grp_gen   = '0;
        grp_prop  = '0;
        out_ready = 1'b1;
        prod_done = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_flags",     32'({cout, ovf, out_last}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x0F + 0x01, single beat, visible the cycle after accept
        check("t1_pre_valid", 32'(out_valid), 32'd0);
        push_beat(8'h0F, 8'h01, 1'b0, 1'b1, 1'b1);
        check_head("t1", 8'h10, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_drained", 32'(out_valid), 32'd0);

        // 2: two-beat add 0x00FF + 0x0001 with the carry chained into beat 2
        out_ready = 1'b0;
        push_beat(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        check_head("t2_b1", 8'h00, 1'b1, 1'b0, 1'b0);
        push_beat(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        check("t2_head_held", 32'(sum), 32'h00);
        out_ready = 1'b1;
        @(negedge clk);
        check_head("t2_b2", 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t2_drained", 32'(out_valid), 32'd0);
        check("t2_in_ready", 32'(in_ready), 32'd1);

        // 3: 0x7F + 0x01 overflows into the sign bit
        push_beat(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
        check_head("t3", 8'h80, 1'b0, 1'b1, 1'b1);
        @(negedge clk);

        // 4: backpressure with three beats; third waits until a slot frees
        out_ready = 1'b0;
        push_beat(8'h01, 8'h02, 1'b0, 1'b1, 1'b1);
        push_beat(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
        check("t4_full_in_ready", 32'(in_ready), 32'd0);
        check("t4_head1", 32'(sum), 32'h03);
        begin
            logic [7:0] g;
            logic [7:0] p;
            tree(8'h40, 8'h05, g, p);
            prop_bit = 8'h40 ^ 8'h05;
            grp_gen  = g;
            grp_prop = p;
            in_first = 1'b1;
            in_last  = 1'b1;
            cin      = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        check("t4_still_full", 32'(in_ready), 32'd0);
        check("t4_head1_stable", 32'(sum), 32'h03);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_slot_freed", 32'(in_ready), 32'd1);
        check_head("t4_b2", 8'h30, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check_head("t4_b3", 8'h45, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_drained", 32'(out_valid), 32'd0);

        // 5: reset between beat 1 and beat 2 discards the FIFO and the carry chain
        out_ready = 1'b0;
        push_beat(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check("t5_rst_sum",       32'(sum),       32'd0);
        check("t5_rst_flags",     32'({cout, ovf, out_last}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        push_beat(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_head("t5_carry_cleared", 8'h00, 1'b0, 1'b0, 1'b1);
        push_beat(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check_head("t5_new_add", 8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // 6: random multi-beat adds against a wide-integer model
        fork
            begin
                int beats = 0;
                while (beats < 1000) begin
                    int          n;
                    logic [31:0] a_w;
                    logic [31:0] b_w;
                    logic        c;
                    n   = $urandom_range(1, 4);
                    a_w = $urandom;
                    b_w = $urandom;
                    c   = 1'($urandom_range(0, 1));
                    for (int k = 0; k < n; k++) begin
                        logic [63:0] mask;
                        logic [63:0] s;
                        exp_t        e;
                        int          m;
                        mask   = (64'd1 << (8 * (k + 1))) - 64'd1;
                        s      = ({32'b0, a_w} & mask) + ({32'b0, b_w} & mask) + {63'b0, c};
                        m      = 8 * k + 7;
                        e.sum  = s[8*k +: 8];
                        e.cout = s[8*k + 8];
                        e.ovf  = (a_w[m] == b_w[m]) && (s[m] != a_w[m]);
                        e.last = (k == n - 1);
                        exp_q.push_back(e);
                        // non-first beats get a random cin to show it is ignored
                        push_beat(a_w[8*k +: 8], b_w[8*k +: 8],
                                  (k == 0) ? c : 1'($urandom_range(0, 1)),
                                  k == 0, k == n - 1);
                        beats++;
                        if ($urandom_range(0, 7) == 0) @(negedge clk);
                    end
                end
                prod_done = 1'b1;
            end
            begin
                int cyc = 0;
                while (!(prod_done && exp_q.size() == 0) && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_spurious_beat", 32'd1, 32'd0);
                        end else begin
                            check("rand_sum",  32'(sum),      32'(exp_q[0].sum));
                            check("rand_cout", 32'(cout),     32'(exp_q[0].cout));
                            check("rand_ovf",  32'(ovf),      32'(exp_q[0].ovf));
                            check("rand_last", 32'(out_last), 32'(exp_q[0].last));
                            void'(exp_q.pop_front());
                        end
                    end
                end
                check("rand_drained", 32'(exp_q.size()), 32'd0);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
